// File: rtl/video_timing_gen.sv
// Raster timing generator with pixel-fetch alignment for the TMDS encoders.
// Scans the frame, requests pixels from a fixed-latency source and delays the
// sync/blanking sideband so rgb, syncs and draw_area leave cycle-aligned.
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int SYNC_POL  = 1,
  parameter int FETCH_LAT = 2
) (
  input  logic        pixclk,
  input  logic        rst,
  input  logic        en,
  output logic        pix_req,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  input  logic [23:0] pix_rgb,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        draw_area,
  output logic        frame_start,
  output logic        busy
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOT - 1);
  // 11-bit bounds so a total of exactly 1024 still compares correctly
  localparam logic [10:0] H_DE_END = 11'(H_ACTIVE);
  localparam logic [10:0] H_HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_DE_END = 11'(V_ACTIVE);
  localparam logic [10:0] V_VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  // Level of an inactive sync pin; also the xor mask applied to raw syncs
  localparam logic        SYNC_INACT = (SYNC_POL == 0);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [9:0]  r_cx;
  logic [9:0]  r_cy;
  logic        w_h_wrap;
  logic        w_frame_wrap;
  logic        w_scanning;
  logic        w_in_active;
  logic [3:0]  w_raw;     // {de, hs, vs, fs}, active-true
  logic [3:0]  w_tap;     // raw sideband delayed by FETCH_LAT cycles
  logic        r_de;
  logic        r_hs;
  logic        r_vs;
  logic        r_fs;
  logic [23:0] r_rgb;

  assign w_h_wrap     = (r_cx == H_LAST);
  assign w_frame_wrap = w_h_wrap && (r_cy == V_LAST);
  assign w_in_active  = ({1'b0, r_cx} < H_DE_END) && ({1'b0, r_cy} < V_DE_END);

  // State register
  always_ff @(posedge pixclk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: DRAIN lets the current frame finish unless en returns
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (en) w_state_next = ST_RUN;
      ST_RUN:   if (!en) w_state_next = w_frame_wrap ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (en) begin
          w_state_next = ST_RUN;
        end else if (w_frame_wrap) begin
          w_state_next = ST_IDLE;
        end
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: requests only while running, scan flag for the sideband
  always_comb begin
    w_scanning = (r_state != ST_IDLE);
    busy       = w_scanning;
    pix_req    = (r_state == ST_RUN) && w_in_active;
  end

  // Raster counters; held at the origin while idle
  always_ff @(posedge pixclk) begin
    if (rst || (r_state == ST_IDLE)) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (w_h_wrap) begin
      r_cx <= '0;
      r_cy <= (r_cy == V_LAST) ? '0 : r_cy + 10'd1;
    end else begin
      r_cx <= r_cx + 10'd1;
    end
  end

  assign pix_x = r_cx;
  assign pix_y = r_cy;

  // Raw sideband is forced blank while idle so the pipeline flushes to blank
  assign w_raw[3] = w_scanning && w_in_active;
  assign w_raw[2] = w_scanning && ({1'b0, r_cx} >= H_HS_BEG) && ({1'b0, r_cx} < H_HS_END);
  assign w_raw[1] = w_scanning && ({1'b0, r_cy} >= V_VS_BEG) && ({1'b0, r_cy} < V_VS_END);
  assign w_raw[0] = w_scanning && (r_cx == 10'd0) && (r_cy == 10'd0);

  generate
    if (FETCH_LAT == 0) begin : g_tap_direct
      assign w_tap = w_raw;
    end else begin : g_tap_pipe
      logic [FETCH_LAT-1:0][3:0] r_dly;

      // Sideband delay line matching the pixel source latency
      always_ff @(posedge pixclk) begin
        if (rst) begin
          r_dly <= '0;
        end else begin
          r_dly[0] <= w_raw;
          for (int i = 1; i < FETCH_LAT; i++) begin
            r_dly[i] <= r_dly[i-1];
          end
        end
      end

      assign w_tap = r_dly[FETCH_LAT-1];
    end
  endgenerate

  // Output stage: capture returned pixel, blank rgb outside the active area
  always_ff @(posedge pixclk) begin
    if (rst) begin
      r_de  <= 1'b0;
      r_hs  <= SYNC_INACT;
      r_vs  <= SYNC_INACT;
      r_fs  <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_de  <= w_tap[3];
      r_hs  <= w_tap[2] ^ SYNC_INACT;
      r_vs  <= w_tap[1] ^ SYNC_INACT;
      r_fs  <= w_tap[0];
      r_rgb <= w_tap[3] ? pix_rgb : 24'h0;
    end
  end

  assign red         = r_rgb[23:16];
  assign green       = r_rgb[15:8];
  assign blue        = r_rgb[7:0];
  assign draw_area   = r_de;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three instances on a small 16x11 raster
// (latencies 1, 3 and 8 cycles; one with active-low syncs) driven by a shared
// en/rst. A stimulus-side model pushes expected outputs into per-instance
// queues; a monitor pops and compares every cycle. Directed hand-computed
// checks cover periods, counts, drain length and reset recovery.
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;   // H_TOT = 16
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;   // V_TOT = 11
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2;

  logic clk, rst, en;

  logic busy0, req0, hs0, vs0, de0, fs0;
  logic [9:0] x0, y0;
  logic [7:0] red0, green0, blue0;
  logic [23:0] rgb0;
  logic busy2, req2, hs2, vs2, de2, fs2;
  logic [9:0] x2, y2;
  logic [7:0] red2, green2, blue2;
  logic [23:0] rgb2;
  logic busy7, req7, hs7, vs7, de7, fs7;
  logic [9:0] x7, y7;
  logic [7:0] red7, green7, blue7;
  logic [23:0] rgb7;

  int n_vec = 0;
  int n_err = 0;
  bit m_init = 0;
  int m_state = S_IDLE;
  int m_cx = 0;
  int m_cy = 0;
  logic [27:0] q0[$];
  logic [27:0] q2[$];
  logic [27:0] q7[$];

  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1), .FETCH_LAT(0)) u0 (
    .pixclk(clk), .rst(rst), .en(en), .pix_req(req0), .pix_x(x0), .pix_y(y0),
    .pix_rgb(rgb0), .red(red0), .green(green0), .blue(blue0), .hsync(hs0),
    .vsync(vs0), .draw_area(de0), .frame_start(fs0), .busy(busy0));

  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0), .FETCH_LAT(2)) u2 (
    .pixclk(clk), .rst(rst), .en(en), .pix_req(req2), .pix_x(x2), .pix_y(y2),
    .pix_rgb(rgb2), .red(red2), .green(green2), .blue(blue2), .hsync(hs2),
    .vsync(vs2), .draw_area(de2), .frame_start(fs2), .busy(busy2));

  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1), .FETCH_LAT(7)) u7 (
    .pixclk(clk), .rst(rst), .en(en), .pix_req(req7), .pix_x(x7), .pix_y(y7),
    .pix_rgb(rgb7), .red(red7), .green(green7), .blue(blue7), .hsync(hs7),
    .vsync(vs7), .draw_area(de7), .frame_start(fs7), .busy(busy7));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pixel source: pattern inside the active area, garbage elsewhere
  function automatic logic [23:0] src(input logic [9:0] x, input logic [9:0] y);
    if (x < 10'(HA) && y < 10'(VA)) return {x[7:0], y[7:0], 8'hA5};
    return 24'hC3C3C3;
  endfunction

  logic [23:0] s2 [2];
  logic [23:0] s7 [7];
  assign rgb0 = src(x0, y0);
  assign rgb2 = s2[1];
  assign rgb7 = s7[6];

  always @(posedge clk) begin
    s2[0] <= src(x2, y2);
    s2[1] <= s2[0];
    s7[0] <= src(x7, y7);
    for (int i = 1; i < 7; i++) s7[i] <= s7[i-1];
  end

  // Expected output tuple {rgb, de, hsync, vsync, frame_start} for a counter state
  function automatic logic [27:0] f_exp(input int st, input int cx, input int cy, input bit pol);
    logic act, de, hs, vs, fs;
    logic [7:0] xb, yb;
    logic [23:0] rgb;
    act = (st != S_IDLE);
    de  = act && cx < HA && cy < VA;
    hs  = act && cx >= HA + HF && cx < HA + HF + HS;
    vs  = act && cy >= VA + VF && cy < VA + VF + VS;
    fs  = act && cx == 0 && cy == 0;
    xb  = 8'(cx);
    yb  = 8'(cy);
    rgb = de ? {xb, yb, 8'hA5} : 24'h0;
    return {rgb, de, hs ^ !pol, vs ^ !pol, fs};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: advances the reference raster and pushes expected outputs
  initial begin
    int nst;
    bit wrap;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_state = S_IDLE; m_cx = 0; m_cy = 0;
        q0.delete(); q2.delete(); q7.delete();
        q0.push_back(f_exp(S_IDLE, 0, 0, 1'b1));
        for (int i = 0; i < 3; i++) q2.push_back(f_exp(S_IDLE, 0, 0, 1'b0));
        for (int i = 0; i < 8; i++) q7.push_back(f_exp(S_IDLE, 0, 0, 1'b1));
        m_init = 1;
      end else if (m_init) begin
        wrap = (m_cx == HT - 1) && (m_cy == VT - 1);
        nst = m_state;
        case (m_state)
          S_IDLE:  if (en) nst = S_RUN;
          S_RUN:   if (!en) nst = wrap ? S_IDLE : S_DRAIN;
          default: if (en) nst = S_RUN; else if (wrap) nst = S_IDLE;
        endcase
        if (m_state != S_IDLE) begin
          if (m_cx == HT - 1) begin
            m_cx = 0;
            m_cy = (m_cy == VT - 1) ? 0 : m_cy + 1;
          end else begin
            m_cx = m_cx + 1;
          end
        end
        m_state = nst;
      end
      if (m_init) begin
        q0.push_back(f_exp(m_state, m_cx, m_cy, 1'b1));
        q2.push_back(f_exp(m_state, m_cx, m_cy, 1'b0));
        q7.push_back(f_exp(m_state, m_cx, m_cy, 1'b1));
      end
    end
  end

  // Monitor: compares request side and pops one aligned output per cycle
  initial begin
    logic [21:0] ef;
    forever begin
      @(negedge clk);
      if (m_init) begin
        ef = {m_state != S_IDLE, (m_state == S_RUN) && m_cx < HA && m_cy < VA,
              10'(m_cx), 10'(m_cy)};
        chk("front_lat1", 32'({busy0, req0, x0, y0}), 32'(ef));
        chk("front_lat3", 32'({busy2, req2, x2, y2}), 32'(ef));
        chk("front_lat8", 32'({busy7, req7, x7, y7}), 32'(ef));
        if (q0.size() == 0 || q2.size() == 0 || q7.size() == 0) begin
          chk("queue_underflow", 32'(q0.size() * q2.size() * q7.size()), 32'd1);
        end else begin
          chk("out_lat1", 32'({red0, green0, blue0, de0, hs0, vs0, fs0}), 32'(q0.pop_front()));
          chk("out_lat3", 32'({red2, green2, blue2, de2, hs2, vs2, fs2}), 32'(q2.pop_front()));
          chk("out_lat8", 32'({red7, green7, blue7, de7, hs7, vs7, fs7}), 32'(q7.pop_front()));
        end
      end
    end
  end

  // Directed measurements accumulated by run_cycles
  int cyc = 0;
  int fs_n, t_fs1, t_fs2, de_c, hs_c, vs_c, t_px, t_hs, busy_low, req_c;

  task automatic clear_meas();
    fs_n = 0; t_fs1 = -1; t_fs2 = -1; de_c = 0; hs_c = 0; vs_c = 0;
    t_px = -1; t_hs = -1; busy_low = 0; req_c = 0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (fs7) begin
        fs_n++;
        if (fs_n == 1) t_fs1 = cyc;
        if (fs_n == 2) t_fs2 = cyc;
      end
      if (fs_n == 1) begin
        de_c += int'(de7); hs_c += int'(hs7); vs_c += int'(vs7);
      end
      if (t_px < 0 && busy2 && x2 == 10'd10) t_px = cyc;
      else if (t_px >= 0 && t_hs < 0 && hs2 == 1'b0) t_hs = cyc;
      if (!busy0) busy_low++;
      req_c += int'(req0) + int'(req2) + int'(req7);
    end
  endtask

  task automatic wait_xy(input int x, input int y);
    bit ok;
    ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (busy0 && x0 == 10'(x) && y0 == 10'(y)) ok = 1;
    end
    if (!ok) chk("wait_xy_timeout", 32'd0, 32'((x << 16) | y));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k0, k2, k7;
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'({busy0, busy2, busy7}), 32'd0);
    chk("rst_req", 32'({req0, req2, req7}), 32'd0);
    chk("rst_sync_lowpol", 32'({hs2, vs2}), 32'b11);
    chk("rst_sync_highpol", 32'({hs0, vs0, hs7, vs7}), 32'd0);
    chk("rst_rgb_de_fs", 32'({red7, green7, blue7, de7, fs7}), 32'd0);
    $display("phase 1: reset held 3 cycles with en=1");

    rst = 1'b0;
    clear_meas();
    run_cycles(420);
    chk("frame_period", 32'(t_fs2 - t_fs1), 32'd176);
    chk("de_per_frame", 32'(de_c), 32'd48);
    chk("hs_per_frame", 32'(hs_c), 32'd33);
    chk("vs_per_frame", 32'(vs_c), 32'd32);
    chk("hs_delay_lat3", 32'(t_hs - t_px), 32'd3);
    $display("phase 2: free-running frames, period %0d", t_fs2 - t_fs1);

    wait_xy(0, 3);
    en = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy0 && k < 400);
    chk("drain_len", 32'(k), 32'd128);
    clear_meas();
    run_cycles(40);
    chk("idle_req", 32'(req_c), 32'd0);
    chk("idle_blank", 32'({red7, green7, blue7, de7, hs7, vs7, fs7}), 32'd0);
    $display("phase 3: en dropped at row 3, drained %0d cycles to idle", k);

    en = 1'b1;
    wait_xy(0, 2);
    en = 1'b0;
    wait_xy(0, 5);
    en = 1'b1;
    clear_meas();
    run_cycles(200);
    chk("rerun_no_gap", 32'(busy_low), 32'd0);
    $display("phase 4: en re-raised during drain, idle cycles %0d", busy_low);

    wait_xy(HT - 1, VT - 1);
    en = 1'b0;
    @(negedge clk);
    chk("last_cycle_to_idle", 32'(busy0), 32'd0);
    repeat (12) @(negedge clk);
    $display("phase 5: en dropped on final frame cycle");

    en = 1'b1;
    wait_xy(5, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", 32'({busy0, busy2, busy7}), 32'd0);
    chk("rst_mid_blank", 32'({red2, green2, blue2, de2, fs2, hs2, vs2}), 32'b11);
    rst = 1'b0;
    k0 = -1; k2 = -1; k7 = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (fs0 && k0 < 0) k0 = i;
      if (fs2 && k2 < 0) k2 = i;
      if (fs7 && k7 < 0) k7 = i;
    end
    chk("fs_after_rst_lat1", 32'(k0), 32'd2);
    chk("fs_after_rst_lat3", 32'(k2), 32'd4);
    chk("fs_after_rst_lat8", 32'(k7), 32'd9);
    $display("phase 6: reset mid-line, frame_start after %0d/%0d/%0d cycles", k0, k2, k7);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
